// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline widths and tag/address types
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_TAG_W  = 4;
    localparam int CPU_NREG   = 32;
    localparam int CPU_AW     = $clog2(CPU_NREG);

    // Tag encoding is common to the reservation stations and the CDB arbiter.
    typedef logic [CPU_TAG_W-1:0] tag_t;
    typedef logic [CPU_AW-1:0]    reg_addr_t;

endpackage

// File: rtl/regfile_tagged_if.sv
// rtl/regfile_tagged_if.sv - read, issue, CDB, flush and debug signals of the tagged register file
interface regfile_tagged_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int NREG   = CPU_NREG,
    parameter int AW     = $clog2(NREG),
    parameter int TAG_W  = CPU_TAG_W,
    parameter int NRD    = 2
) ();

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NRD*TAG_W-1:0]  rd_tag;

    logic                  iss_valid;
    logic [AW-1:0]         iss_addr;
    logic [TAG_W-1:0]      iss_tag;

    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic [DATA_W-1:0]     cdb_data;

    logic                  flush;

    logic [AW-1:0]         dbg_addr;
    logic [DATA_W-1:0]     dbg_data;

    modport slave (
        input  rd_addr, iss_valid, iss_addr, iss_tag,
        input  cdb_valid, cdb_tag, cdb_data, flush, dbg_addr,
        output rd_data, rd_busy, rd_tag, dbg_data
    );

    modport master (
        output rd_addr, iss_valid, iss_addr, iss_tag,
        output cdb_valid, cdb_tag, cdb_data, flush, dbg_addr,
        input  rd_data, rd_busy, rd_tag, dbg_data
    );

endinterface

// File: rtl/regfile_tagged_rdport.sv
// rtl/regfile_tagged_rdport.sv - one combinational read slice with same-cycle CDB bypass
module regfile_tagged_rdport
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int AW     = CPU_AW,
    parameter int TAG_W  = CPU_TAG_W
) (
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_val,
    input  logic              i_busy,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic [TAG_W-1:0]  o_tag
);

    always_comb begin
        o_data = i_val;
        o_busy = i_busy;
        o_tag  = i_tag;
        if (i_addr == '0) begin
            o_data = '0;
            o_busy = 1'b0;
            o_tag  = '0;
        end else if (i_busy && i_cdb_valid && (i_cdb_tag == i_tag)) begin
            // Result is on the bus right now: hand it over instead of the tag.
            o_data = i_cdb_data;
            o_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_tagged.sv
// rtl/regfile_tagged.sv - register file with per-register busy bit and producer tag
module regfile_tagged
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int NREG   = CPU_NREG,
    parameter int AW     = $clog2(NREG),
    parameter int TAG_W  = CPU_TAG_W,
    parameter int NRD    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    regfile_tagged_if.slave bus
);

    logic [DATA_W-1:0]     r_val  [NREG];
    logic [NREG-1:0]       r_busy;
    logic [TAG_W-1:0]      r_tag  [NREG];

    logic [NREG-1:0]       w_cdb_hit;
    logic [NREG-1:0]       w_iss_hit;
    logic [AW-1:0]         w_rd_addr [NRD];
    logic [NRD*DATA_W-1:0] w_rd_data;
    logic [NRD-1:0]        w_rd_busy;
    logic [NRD*TAG_W-1:0]  w_rd_tag;

    // Flush drops a same-cycle issue, so it is folded into the issue hit.
    always_comb begin
        w_cdb_hit = '0;
        w_iss_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            w_cdb_hit[r] = bus.cdb_valid && r_busy[r] && (r_tag[r] == bus.cdb_tag);
            w_iss_hit[r] = bus.iss_valid && !bus.flush && (bus.iss_addr == AW'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                r_val[r] <= '0;
                r_tag[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_cdb_hit[r]) begin
                    r_val[r] <= bus.cdb_data;
                end
                if (bus.flush) begin
                    r_busy[r] <= 1'b0;
                end else if (w_iss_hit[r]) begin
                    r_busy[r] <= 1'b1;
                end else if (w_cdb_hit[r]) begin
                    r_busy[r] <= 1'b0;
                end
                if (w_iss_hit[r]) begin
                    r_tag[r] <= bus.iss_tag;
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign w_rd_addr[i] = bus.rd_addr[i*AW +: AW];

        regfile_tagged_rdport #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .TAG_W  (TAG_W)
        ) u_rdport (
            .i_addr      (w_rd_addr[i]),
            .i_val       (r_val[w_rd_addr[i]]),
            .i_busy      (r_busy[w_rd_addr[i]]),
            .i_tag       (r_tag[w_rd_addr[i]]),
            .i_cdb_valid (bus.cdb_valid),
            .i_cdb_tag   (bus.cdb_tag),
            .i_cdb_data  (bus.cdb_data),
            .o_data      (w_rd_data[i*DATA_W +: DATA_W]),
            .o_busy      (w_rd_busy[i]),
            .o_tag       (w_rd_tag[i*TAG_W +: TAG_W])
        );
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_busy  = w_rd_busy;
    assign bus.rd_tag   = w_rd_tag;
    assign bus.dbg_data = r_val[bus.dbg_addr];

endmodule

// File: tb/tb_regfile_tagged.sv
// tb/tb_regfile_tagged.sv - scoreboard bench for regfile_tagged
module tb_regfile_tagged;
    import cpu_pkg::*;

    localparam int DW  = 32;
    localparam int AWL = 5;
    localparam int TW  = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_tagged_if rf_if ();

    regfile_tagged u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if)
    );

    typedef struct {
        string       name;
        bit          is_dbg;
        int          port;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  tag;
        bit          cd;
        bit          ct;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s: actual=0x%08h required=0x%08h", nm, fld, act, req);
        end
    endtask

    task automatic rd(input int p, input int a, input logic [31:0] d, input logic b,
                      input logic [3:0] t, input bit cd, input bit ct, input string nm);
        exp_t e;
        rf_if.rd_addr[p*AWL +: AWL] = AWL'(a);
        e.name = nm; e.is_dbg = 1'b0; e.port = p; e.data = d;
        e.busy = b; e.tag = t; e.cd = cd; e.ct = ct;
        sb_q.push_back(e);
    endtask

    task automatic dbg(input int a, input logic [31:0] d, input string nm);
        exp_t e;
        rf_if.dbg_addr = AWL'(a);
        e.name = nm; e.is_dbg = 1'b1; e.port = 0; e.data = d;
        e.busy = 1'b0; e.tag = '0; e.cd = 1'b1; e.ct = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic issue(input int a, input int t);
        rf_if.iss_valid = 1'b1;
        rf_if.iss_addr  = AWL'(a);
        rf_if.iss_tag   = TW'(t);
    endtask

    task automatic cdb(input int t, input logic [31:0] d);
        rf_if.cdb_valid = 1'b1;
        rf_if.cdb_tag   = TW'(t);
        rf_if.cdb_data  = d;
    endtask

    task automatic quiet();
        rf_if.iss_valid = 1'b0;
        rf_if.cdb_valid = 1'b0;
        rf_if.flush     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so every pending expectation is checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.is_dbg) begin
                    cmp(e.name, "dbg_data", rf_if.dbg_data, e.data);
                end else begin
                    if (e.cd) cmp(e.name, "rd_data", rf_if.rd_data[e.port*DW +: DW], e.data);
                    cmp(e.name, "rd_busy", {31'b0, rf_if.rd_busy[e.port]}, {31'b0, e.busy});
                    if (e.ct) cmp(e.name, "rd_tag", {28'b0, rf_if.rd_tag[e.port*TW +: TW]}, {28'b0, e.tag});
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        rf_if.rd_addr  = '0;
        rf_if.iss_addr = '0;
        rf_if.iss_tag  = '0;
        rf_if.cdb_tag  = '0;
        rf_if.cdb_data = '0;
        rf_if.dbg_addr = '0;
        quiet();
        step();
        step();
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            rd(0, a, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1, "reset_p0");
            rd(1, 31 - a, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1, "reset_p1");
            dbg(a, 32'h0, "reset_dbg");
            step();
        end

        issue(5, 3);
        step();
        quiet();
        rd(0, 5, 32'h0, 1'b1, 4'd3, 1'b0, 1'b1, "r5_pending");
        step();
        cdb(3, 32'hDEADBEEF);
        rd(1, 5, 32'hDEADBEEF, 1'b0, 4'd3, 1'b1, 1'b0, "r5_bypass");
        dbg(5, 32'h0, "r5_dbg_nobypass");
        step();
        quiet();
        rd(0, 5, 32'hDEADBEEF, 1'b0, 4'd3, 1'b1, 1'b1, "r5_written");
        dbg(5, 32'hDEADBEEF, "r5_dbg");
        step();

        issue(7, 2);
        step();
        issue(9, 2);
        step();
        quiet();
        cdb(2, 32'h11);
        step();
        quiet();
        rd(0, 7, 32'h11, 1'b0, 4'd2, 1'b1, 1'b1, "r7_multi");
        rd(1, 9, 32'h11, 1'b0, 4'd2, 1'b1, 1'b1, "r9_multi");
        dbg(8, 32'h0, "r8_untouched_dbg");
        step();
        rd(0, 8, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, "r8_untouched");
        step();

        issue(4, 1);
        step();
        issue(4, 6);
        cdb(1, 32'h55);
        step();
        quiet();
        cdb(1, 32'h66);
        rd(0, 4, 32'h55, 1'b1, 4'd6, 1'b1, 1'b1, "r4_reissued");
        dbg(4, 32'h55, "r4_dbg_old_cdb");
        step();
        cdb(6, 32'h77);
        rd(1, 4, 32'h77, 1'b0, 4'd6, 1'b1, 1'b0, "r4_bypass_new");
        dbg(4, 32'h55, "r4_stale_tag_ignored");
        step();
        quiet();
        rd(0, 4, 32'h77, 1'b0, 4'd6, 1'b1, 1'b1, "r4_final");
        dbg(4, 32'h77, "r4_dbg_final");
        step();

        issue(0, 2);
        step();
        quiet();
        cdb(2, 32'hFF);
        rd(0, 0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, "r0_cdb_cycle");
        rd(1, 7, 32'h11, 1'b0, 4'd2, 1'b1, 1'b1, "r7_not_busy_no_bypass");
        step();
        quiet();
        rd(0, 0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, "r0_after");
        rd(1, 7, 32'h11, 1'b0, 4'd2, 1'b1, 1'b1, "r7_retained");
        dbg(0, 32'h0, "r0_dbg");
        issue(3, 5);
        rf_if.flush = 1'b1;
        step();
        quiet();
        rd(0, 3, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, "r3_issue_flushed");
        step();

        issue(6, 7);
        step();
        issue(12, 8);
        step();
        quiet();
        rf_if.flush = 1'b1;
        cdb(7, 32'h99);
        rd(0, 6, 32'h99, 1'b0, 4'd7, 1'b1, 1'b1, "r6_flush_bypass");
        step();
        quiet();
        rd(0, 6, 32'h99, 1'b0, 4'd7, 1'b1, 1'b1, "r6_flush_cdb_written");
        rd(1, 12, 32'h0, 1'b0, 4'd8, 1'b1, 1'b1, "r12_flush_keeps_tag");
        step();

        issue(10, 4);
        step();
        quiet();
        rst_n = 1'b0;
        cdb(4, 32'hAA);
        step();
        rst_n = 1'b1;
        quiet();
        rd(0, 10, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, "r10_reset_wins");
        rd(1, 6, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, "r6_reset");
        dbg(5, 32'h0, "r5_dbg_reset");
        step();

        issue(10, 4);
        rf_if.flush = 1'b1;
        cdb(4, 32'hAA);
        step();
        quiet();
        rd(0, 10, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1, "r10_flush_issue_cdb");
        dbg(10, 32'h0, "r10_dbg_no_cdb");
        step();

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: actual=%0d pending required=0 pending", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
